hwpe_stream_tcdm_load_issuer: RTL and testbench

- Load-side request stage directly downstream of the stream address generator.
- Consumes generated word addresses and byte strobes, and pulses the generator's enable on every granted request.
- Issues TCDM read requests using req/gnt, with a bounded number outstanding.
- Buffers r_valid responses in a credit-protected FIFO and emits them as a valid/ready HWPE stream, so a stalled consumer never loses data.

---
 rtl/hwpe_stream_tcdm_load_issuer.sv | 183 ++++++++++++++++++
 tb/tb_hwpe_stream_tcdm_load_issuer.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_tcdm_load_issuer.sv
// TCDM load issuer: credit-limited read requests, responses replayed as a stream; data out >= 1 cycle after r_valid.
// Backpressure: a stalled stream fills the response FIFO, which starves credit and holds tcdm_req_o low.

module hwpe_stream_tcdm_load_issuer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
endmodule

module hwpe_stream_tcdm_load_issuer #(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT             = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [CNT-1:0]          trans_size_i,
   input  logic [31:0]             addr_i,
   input  logic [DATA_WIDTH/8-1:0] strb_i,
   output logic                    addr_enable_o,
   output logic                    tcdm_req_o,
   input  logic                    tcdm_gnt_i,
   output logic [31:0]             tcdm_add_o,
   output logic                    tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
   input  logic                    tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
   output logic                    stream_valid_o,
   output logic [DATA_WIDTH-1:0]   stream_data_o,
   output logic [DATA_WIDTH/8-1:0] stream_strb_o,
   input  logic                    stream_ready_i,
   output logic                    busy_o,
   output logic                    done_o
);
   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [CNT-1:0]         size;
   logic [CNT-1:0]         req_cnt;
   logic [CNT-1:0]         rsp_cnt;
   logic [CW-1:0]          inflight;
   logic [CW-1:0]          fifo_count;
   logic [CW:0]            credit_used;
   logic [CW:0]            fifo_count_nxt;
   logic                   grant;
   logic                   rsp;
   logic                   pop;
   logic                   last_grant;
   logic                   fifo_full;
   logic [BW-1:0]          side_strb;
   logic [DATA_WIDTH+BW-1:0] fifo_out;

   // The strobe side queue holds exactly one entry per granted, unanswered request,
   // so its occupancy doubles as the in-flight count.
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign tcdm_req_o  = (state == ISSUE) && (credit_used < (CW+1)'(MAX_OUTSTANDING));
   assign grant       = tcdm_req_o && tcdm_gnt_i;
   assign rsp         = tcdm_r_valid_i && ((state == ISSUE) || (state == DRAIN)) && (inflight != '0);
   assign pop         = stream_valid_o && stream_ready_i;
   assign last_grant  = grant && ((req_cnt + CNT'(1)) == size);
   assign fifo_full   = (fifo_count == CW'(MAX_OUTSTANDING));
   assign fifo_count_nxt = {1'b0, fifo_count} + (CW+1)'(rsp) - (CW+1)'(pop);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = (trans_size_i != '0) ? ISSUE : DONE;
         ISSUE:   if (last_grant) state_nxt = DRAIN;
         DRAIN:   if ((rsp_cnt == size) && (fifo_count_nxt == '0)) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         size    <= '0;
         req_cnt <= '0;
         rsp_cnt <= '0;
      end else if (clear_i) begin
         state   <= IDLE;
         size    <= '0;
         req_cnt <= '0;
         rsp_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start_i) begin
            size    <= trans_size_i;
            req_cnt <= '0;
            rsp_cnt <= '0;
         end else begin
            if (grant) req_cnt <= req_cnt + CNT'(1);
            if (rsp)   rsp_cnt <= rsp_cnt + CNT'(1);
         end
      end
   end

   hwpe_stream_tcdm_load_issuer_fifo #(.WIDTH(BW), .DEPTH(MAX_OUTSTANDING)) i_strb_queue (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (clear_i),
      .push      (grant),
      .push_data (strb_i),
      .pop       (rsp),
      .pop_data  (side_strb),
      .count     (inflight)
   );

   hwpe_stream_tcdm_load_issuer_fifo #(.WIDTH(DATA_WIDTH + BW), .DEPTH(MAX_OUTSTANDING)) i_rsp_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (clear_i),
      .push      (rsp),
      .push_data ({tcdm_r_data_i, side_strb}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_count)
   );

   assign stream_valid_o = (fifo_count != '0);
   assign stream_data_o  = stream_valid_o ? fifo_out[BW +: DATA_WIDTH] : '0;
   assign stream_strb_o  = stream_valid_o ? fifo_out[BW-1:0] : '0;

   assign addr_enable_o = grant;
   assign tcdm_add_o    = addr_i;
   assign tcdm_be_o     = strb_i;
   assign tcdm_wen_o    = 1'b1;
   assign busy_o        = (state == ISSUE) || (state == DRAIN);
   assign done_o        = (state == DONE);

   // Credit accounting makes this unreachable unless the memory breaks the 1-cycle response rule.
   a_rsp_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) rsp |-> !fifo_full);
endmodule

// File: tb/tb_hwpe_stream_tcdm_load_issuer.sv
// Bench for hwpe_stream_tcdm_load_issuer: TCDM memory plus address generator model, expected
// stream computed from base address, word index and strobe table.

module tb_hwpe_stream_tcdm_load_issuer;
   localparam int DW   = 32;
   localparam int MAXO = 4;
   localparam int CNT  = 16;
   localparam int BW   = DW / 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [BW-1:0] strb;
   } word_t;

   logic           clk_i;
   logic           rst_i, clear_i, start_i;
   logic [CNT-1:0] trans_size_i;
   logic [31:0]    addr_i;
   logic [BW-1:0]  strb_i;
   logic           addr_enable_o, tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
   logic [31:0]    tcdm_add_o;
   logic [BW-1:0]  tcdm_be_o;
   logic           tcdm_r_valid_i;
   logic [DW-1:0]  tcdm_r_data_i;
   logic           stream_valid_o, stream_ready_i, busy_o, done_o;
   logic [DW-1:0]  stream_data_o;
   logic [BW-1:0]  stream_strb_o;

   hwpe_stream_tcdm_load_issuer #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .CNT(CNT)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (clear_i),
      .start_i        (start_i),
      .trans_size_i   (trans_size_i),
      .addr_i         (addr_i),
      .strb_i         (strb_i),
      .addr_enable_o  (addr_enable_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .stream_valid_o (stream_valid_o),
      .stream_data_o  (stream_data_o),
      .stream_strb_o  (stream_strb_o),
      .stream_ready_i (stream_ready_i),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int checks;
   int errors;

   logic [31:0]   base_addr;
   logic [31:0]   salt;
   int            gen_idx;
   logic [BW-1:0] strb_tab [32];
   word_t         exp_q[$];
   word_t         got_q[$];

   logic          s_req, s_en, s_valid, s_done, s_busy, s_grant, s_pop;
   logic [31:0]   s_add;
   logic [BW-1:0] s_be, s_strb;
   logic [DW-1:0] s_data;

   int r_grants, r_first, r_last, r_done_tick, r_max_out;

   // Memory content: each word is its address xor a per-test salt.
   function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
      return a ^ salt;
   endfunction

   task automatic drive_gen();
      addr_i = base_addr + 32'(gen_idx * 4);
      strb_i = strb_tab[gen_idx % 32];
   endtask

   task automatic prep(input int n, input logic [31:0] base, input logic [31:0] s);
      word_t w;
      base_addr = base;
      salt      = s;
      gen_idx   = 0;
      drive_gen();
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         w.data = mem_word(base + 32'(i * 4));
         w.strb = strb_tab[i % 32];
         exp_q.push_back(w);
      end
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic tick(input logic gnt, input logic rdy);
      word_t w;
      tcdm_gnt_i     = gnt;
      stream_ready_i = rdy;
      #1;
      s_req   = tcdm_req_o;
      s_en    = addr_enable_o;
      s_add   = tcdm_add_o;
      s_be    = tcdm_be_o;
      s_valid = stream_valid_o;
      s_data  = stream_data_o;
      s_strb  = stream_strb_o;
      s_done  = done_o;
      s_busy  = busy_o;
      s_grant = s_req && gnt;
      s_pop   = s_valid && rdy;
      if (s_pop) begin
         w.data = s_data;
         w.strb = s_strb;
         got_q.push_back(w);
      end
      @(posedge clk_i);
      #1;
      start_i        = 1'b0;
      clear_i        = 1'b0;
      tcdm_r_valid_i = s_grant;
      tcdm_r_data_i  = s_grant ? mem_word(s_add) : DW'($urandom());
      if (s_en) gen_idx++;
      drive_gen();
      @(negedge clk_i);
   endtask

   task automatic run_xfer(input int n, input int gp, input int rp, input int stall_k, input int budget);
      int outstanding;
      logic g, r;
      outstanding  = 0;
      r_grants     = 0;
      r_first      = -1;
      r_last       = -1;
      r_done_tick  = -1;
      r_max_out    = 0;
      start_i      = 1'b1;
      trans_size_i = CNT'(n);
      for (int k = 0; k < budget; k++) begin
         g = (k != stall_k) && (int'($urandom_range(99)) < gp);
         r = int'($urandom_range(99)) < rp;
         tick(g, r);
         if (s_grant) begin
            if (r_grants == 0) r_first = k;
            r_last = k;
            r_grants++;
            outstanding++;
         end
         if (s_pop) outstanding--;
         if (outstanding > r_max_out) r_max_out = outstanding;
         if (s_done) begin
            r_done_tick = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      checks++;
      if ({tcdm_req_o, addr_enable_o, stream_valid_o, busy_o, done_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got req/en/valid/busy/done=%b expected 00000",
                  {tcdm_req_o, addr_enable_o, stream_valid_o, busy_o, done_o});
      end
      checks++;
      if ({stream_data_o, stream_strb_o} !== '0) begin
         errors++;
         $display("FAIL reset_data got data=%h strb=%b expected 0", stream_data_o, stream_strb_o);
      end
      checks++;
      if (tcdm_wen_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_wen got %b expected 1", tcdm_wen_o);
      end
      rst_i = 1'b0;
      tick(1'b1, 1'b1);
      checks++;
      if ({s_req, s_valid, s_busy, s_done} !== 4'b0) begin
         errors++;
         $display("FAIL idle_after_reset got req/valid/busy/done=%b expected 0000", {s_req, s_valid, s_busy, s_done});
      end
   endtask

   task automatic test_full_rate();
      for (int i = 0; i < 32; i++) strb_tab[i] = '1;
      prep(8, 32'h100, 32'h0);
      run_xfer(8, 100, 100, -1, 60);
      checks++;
      if (r_done_tick < 0) begin errors++; $display("FAIL full_rate_done timeout, no done_o within 60 cycles"); end
      checks++;
      if (r_grants != 8 || r_first != 1 || r_last != 8) begin
         errors++;
         $display("FAIL full_rate_grants got %0d grants at cycles %0d..%0d expected 8 at 1..8", r_grants, r_first, r_last);
      end
      checks++;
      if (r_done_tick != r_last + 3) begin
         errors++;
         $display("FAIL full_rate_done_cycle got %0d expected %0d", r_done_tick, r_last + 3);
      end
      checks++;
      if (got_q.size() != 8) begin errors++; $display("FAIL full_rate_count got %0d words expected 8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL full_rate_word%0d got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].strb, exp_q[i].data, exp_q[i].strb);
         end
      end
   endtask

   task automatic test_back_pressure();
      int   grants;
      logic seen_valid;
      logic done_seen;
      for (int i = 0; i < 32; i++) strb_tab[i] = '1;
      prep(8, 32'h2000, $urandom());
      grants       = 0;
      seen_valid   = 1'b0;
      start_i      = 1'b1;
      trans_size_i = CNT'(8);
      for (int k = 0; k < 12; k++) begin
         tick(1'b1, 1'b0);
         if (s_grant) grants++;
         if (seen_valid) begin
            checks++;
            if (s_valid !== 1'b1 || s_data !== exp_q[0].data || s_strb !== exp_q[0].strb) begin
               errors++;
               $display("FAIL bp_hold cycle %0d got valid=%b data=%h strb=%b expected 1/%h/%b",
                        k, s_valid, s_data, s_strb, exp_q[0].data, exp_q[0].strb);
            end
         end
         if (s_valid) seen_valid = 1'b1;
      end
      checks++;
      if (grants != MAXO || s_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_credit got %0d grants, req=%b expected %0d grants, req=0", grants, s_req, MAXO);
      end
      done_seen = 1'b0;
      for (int k = 0; k < 80 && !done_seen; k++) begin
         tick(1'b1, 1'b1);
         if (s_done) done_seen = 1'b1;
      end
      checks++;
      if (!done_seen || got_q.size() != 8) begin
         errors++;
         $display("FAIL bp_release got done=%b words=%0d expected done=1 words=8", done_seen, got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_word%0d got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].strb, exp_q[i].data, exp_q[i].strb);
         end
      end
   endtask

   task automatic test_grant_stall();
      logic [31:0]   held_add;
      logic [BW-1:0] held_be;
      logic          done_seen;
      for (int i = 0; i < 32; i++) strb_tab[i] = BW'($urandom_range(1, 15));
      prep(6, 32'h4000, $urandom());
      held_add     = '0;
      held_be      = '0;
      done_seen    = 1'b0;
      start_i      = 1'b1;
      trans_size_i = CNT'(6);
      for (int k = 0; k < 60 && !done_seen; k++) begin
         tick(!(k >= 3 && k <= 7), 1'b1);
         if (k == 3) begin
            held_add = s_add;
            held_be  = s_be;
            checks++;
            if (s_add !== base_addr + 32'd8 || s_be !== strb_tab[2]) begin
               errors++;
               $display("FAIL stall_addr got %h/%b expected %h/%b", s_add, s_be, base_addr + 32'd8, strb_tab[2]);
            end
         end
         if (k >= 3 && k <= 7) begin
            checks++;
            if (s_req !== 1'b1 || s_en !== 1'b0 || s_add !== held_add || s_be !== held_be) begin
               errors++;
               $display("FAIL stall_hold cycle %0d got req=%b en=%b add=%h be=%b expected 1/0/%h/%b",
                        k, s_req, s_en, s_add, s_be, held_add, held_be);
            end
         end
         if (s_done) done_seen = 1'b1;
      end
      checks++;
      if (!done_seen || got_q.size() != 6) begin
         errors++;
         $display("FAIL stall_complete got done=%b words=%0d expected done=1 words=6", done_seen, got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall_word%0d got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].strb, exp_q[i].data, exp_q[i].strb);
         end
      end
   endtask

   task automatic test_zero_size();
      logic any_req;
      prep(0, 32'h5000, 32'h0);
      any_req      = 1'b0;
      start_i      = 1'b1;
      trans_size_i = '0;
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b1);
         if (s_req) any_req = 1'b1;
         if (k == 1) begin
            checks++;
            if (s_done !== 1'b1 || s_busy !== 1'b0) begin
               errors++;
               $display("FAIL zero_done got done=%b busy=%b expected 1/0", s_done, s_busy);
            end
         end
         if (k == 2) begin
            checks++;
            if (s_done !== 1'b0) begin errors++; $display("FAIL zero_pulse got done=%b expected 0", s_done); end
         end
      end
      checks++;
      if (any_req) begin errors++; $display("FAIL zero_no_req got req seen=1 expected 0"); end
   endtask

   task automatic test_clear();
      int grants;
      prep(8, 32'h6000, $urandom());
      grants       = 0;
      start_i      = 1'b1;
      trans_size_i = CNT'(8);
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b0);
         if (s_grant) grants++;
      end
      checks++;
      if (grants != 3) begin errors++; $display("FAIL clear_pre_grants got %0d expected 3", grants); end
      // The grant coinciding with clear produces a stale r_valid in the following cycle.
      clear_i = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_req !== 1'b0) begin
         errors++;
         $display("FAIL clear_state got valid=%b busy=%b req=%b expected 0/0/0", s_valid, s_busy, s_req);
      end
      tick(1'b1, 1'b0);
      checks++;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL clear_stale_drop got valid=%b expected 0", s_valid); end
      prep(2, 32'h7000, $urandom());
      run_xfer(2, 100, 100, -1, 40);
      checks++;
      if (r_done_tick < 0 || r_grants != 2 || got_q.size() != 2) begin
         errors++;
         $display("FAIL clear_restart got done_tick=%0d grants=%0d words=%0d expected done, 2, 2",
                  r_done_tick, r_grants, got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL clear_word%0d got %h/%b expected %h/%b", i, got_q[i].data, got_q[i].strb, exp_q[i].data, exp_q[i].strb);
         end
      end
   endtask

   task automatic test_strobe_align();
      logic [BW-1:0] exp_strb [3];
      exp_strb[0] = 4'b1100;
      exp_strb[1] = 4'b1111;
      exp_strb[2] = 4'b0011;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 32; i++) strb_tab[i] = '1;
         strb_tab[0] = 4'b1100;
         strb_tab[2] = 4'b0011;
         prep(3, 32'h8000 + 32'(pass * 32'h100), $urandom());
         run_xfer(3, 100, 100, (pass == 0) ? -1 : 2, 40);
         checks++;
         if (r_done_tick < 0 || got_q.size() != 3) begin
            errors++;
            $display("FAIL strb_pass%0d_complete got done_tick=%0d words=%0d expected done, 3", pass, r_done_tick, got_q.size());
         end
         for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++;
            if (got_q[i].strb !== exp_strb[i] || got_q[i].data !== mem_word(base_addr + 32'(i * 4))) begin
               errors++;
               $display("FAIL strb_pass%0d_word%0d got %h/%b expected %h/%b", pass, i, got_q[i].data, got_q[i].strb,
                        mem_word(base_addr + 32'(i * 4)), exp_strb[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int bad;
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 20);
         for (int i = 0; i < 32; i++) strb_tab[i] = BW'($urandom_range(1, 15));
         prep(n, {$urandom_range(0, 32'hFFFF), 2'b00} << 4, $urandom());
         run_xfer(n, $urandom_range(40, 100), $urandom_range(30, 100), -1, 400);
         checks++;
         if (r_done_tick < 0 || r_grants != n || r_max_out > MAXO) begin
            errors++;
            $display("FAIL b2b%0d_ctrl got done_tick=%0d grants=%0d max_outstanding=%0d expected done, %0d, <=%0d",
                     t, r_done_tick, r_grants, r_max_out, n, MAXO);
         end
         bad = 0;
         for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
         checks++;
         if (bad != 0 || got_q.size() != n) begin
            errors++;
            $display("FAIL b2b%0d_stream got %0d words with %0d wrong expected %0d words in order", t, got_q.size(), bad, n);
         end
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_i          = 1'b1;
      clear_i        = 1'b0;
      start_i        = 1'b0;
      trans_size_i   = '0;
      tcdm_gnt_i     = 1'b0;
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = '0;
      stream_ready_i = 1'b0;
      base_addr      = '0;
      salt           = '0;
      gen_idx        = 0;
      for (int i = 0; i < 32; i++) strb_tab[i] = '1;
      drive_gen();
      test_reset();
      test_full_rate();
      test_back_pressure();
      test_grant_stall();
      test_zero_size();
      test_clear();
      test_strobe_align();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
